// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load writebacks onto the single register-file
// write port. Each source feeds a small queue; queue heads are granted round-robin,
// except that when both heads target the same register the older one (by age tag)
// goes first so program order is kept. Port outputs and pend_mask are registered.
//
// last_grant | meaning
// LAST_ALU   | ALU head took the previous grant; MEM wins the next contested grant
// LAST_MEM   | MEM head took the previous grant (reset value); ALU wins the next one

module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alu_valid_i,
    output logic                    alu_ready_o,
    input  logic [ADDR_W-1:0]       alu_reg_i,
    input  logic [DATA_W-1:0]       alu_data_i,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [ADDR_W-1:0]       mem_reg_i,
    input  logic [DATA_W-1:0]       mem_data_i,
    output logic [ADDR_W-1:0]       reg_write_o,
    output logic [DATA_W-1:0]       write_data_o,
    output logic                    regwrite_con_o,
    output logic [(2**ADDR_W)-1:0]  pend_mask_o,
    output logic [$clog2(DEPTH):0]  alu_count_o,
    output logic [$clog2(DEPTH):0]  mem_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;
    localparam int ALU   = 0;
    localparam int MEM   = 1;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [SEQ_W-1:0] HALF = SEQ_W'(1 << (SEQ_W - 1));

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } last_e;

    last_e last_q, last_d;

    // Source-indexed views of the two request ports (0 = ALU, 1 = MEM)
    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_reg  [2];
    logic [DATA_W-1:0] in_data [2];

    logic [1:0] in_ready;
    logic [1:0] enq;
    logic [1:0] grant;
    logic [1:0] nonempty;

    logic [ADDR_W-1:0] q_reg_q  [2][DEPTH];
    logic [ADDR_W-1:0] q_reg_d  [2][DEPTH];
    logic [DATA_W-1:0] q_data_q [2][DEPTH];
    logic [SEQ_W-1:0]  q_seq_q  [2][DEPTH];

    logic [PTR_W-1:0] wr_q [2], wr_d [2];
    logic [PTR_W-1:0] rd_q [2], rd_d [2];
    logic [CNT_W-1:0] cnt_q [2], cnt_d [2];

    logic [ADDR_W-1:0] head_reg  [2];
    logic [DATA_W-1:0] head_data [2];
    logic [SEQ_W-1:0]  head_seq  [2];

    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] enq_seq [2];
    logic [SEQ_W-1:0] seq_diff;
    logic             alu_older;

    logic              wcon_q, wcon_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic [PTR_W-1:0]  slot_off;

    assign in_valid      = {mem_valid_i, alu_valid_i};
    assign in_reg[ALU]   = alu_reg_i;
    assign in_reg[MEM]   = mem_reg_i;
    assign in_data[ALU]  = alu_data_i;
    assign in_data[MEM]  = mem_data_i;

    // Ready comes only from registered occupancy; writes to r0 are swallowed at the door
    always_comb begin
        in_ready = '0;
        enq      = '0;
        for (int s = 0; s < 2; s++) begin
            in_ready[s] = (cnt_q[s] < FULL);
            enq[s]      = in_valid[s] && in_ready[s] && (in_reg[s] != '0);
        end
    end

    // Age tags: ALU takes the current value, MEM the next one if both enqueue together
    always_comb begin
        enq_seq[ALU] = seq_q;
        enq_seq[MEM] = seq_q + {{(SEQ_W-1){1'b0}}, enq[ALU]};
        seq_d        = enq_seq[MEM] + {{(SEQ_W-1){1'b0}}, enq[MEM]};
    end

    // Queue head fields, read from registered storage only
    always_comb begin
        nonempty = '0;
        for (int s = 0; s < 2; s++) begin
            nonempty[s]  = (cnt_q[s] != '0);
            head_reg[s]  = q_reg_q[s][rd_q[s]];
            head_data[s] = q_data_q[s][rd_q[s]];
            head_seq[s]  = q_seq_q[s][rd_q[s]];
        end
    end

    // Wrap-aware age compare: ALU is older when MEM's tag is 1..HALF-1 ahead
    assign seq_diff  = head_seq[MEM] - head_seq[ALU];
    assign alu_older = (seq_diff != '0) && (seq_diff < HALF);

    // Arbitration and last-grant next state
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (nonempty[ALU] && nonempty[MEM]) begin
            if (head_reg[ALU] == head_reg[MEM]) begin
                grant = alu_older ? 2'b01 : 2'b10;
            end else begin
                grant = (last_q == LAST_MEM) ? 2'b01 : 2'b10;
            end
        end else if (nonempty[ALU]) begin
            grant = 2'b01;
        end else if (nonempty[MEM]) begin
            grant = 2'b10;
        end
        if (grant[ALU]) begin
            last_d = LAST_ALU;
        end else if (grant[MEM]) begin
            last_d = LAST_MEM;
        end
    end

    // Last-grant state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= LAST_MEM;
        end else begin
            last_q <= last_d;
        end
    end

    // Queue pointer, occupancy and register-field next state
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr_d[s]  = wr_q[s] + PTR_W'(enq[s]);
            rd_d[s]  = rd_q[s] + PTR_W'(grant[s]);
            cnt_d[s] = cnt_q[s] + CNT_W'(enq[s]) - CNT_W'(grant[s]);
            for (int i = 0; i < DEPTH; i++) begin
                q_reg_d[s][i] = q_reg_q[s][i];
            end
            if (enq[s]) begin
                q_reg_d[s][wr_q[s]] = in_reg[s];
            end
        end
    end

    // Write-port next state: load on a grant, otherwise only drop the enable
    always_comb begin
        wcon_d  = |grant;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (grant[ALU]) begin
            wreg_d  = head_reg[ALU];
            wdata_d = head_data[ALU];
        end else if (grant[MEM]) begin
            wreg_d  = head_reg[MEM];
            wdata_d = head_data[MEM];
        end
    end

    // Pending mask built from the post-edge queue contents plus the post-edge port
    always_comb begin
        pend_d   = '0;
        slot_off = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_off = PTR_W'(i) - rd_d[s];
                if ({1'b0, slot_off} < cnt_d[s]) begin
                    pend_d[q_reg_d[s][i]] = 1'b1;
                end
            end
        end
        if (wcon_d) begin
            pend_d[wreg_d] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Control state: pointers, counts, sequence counter, port and mask registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < 2; s++) begin
                wr_q[s]  <= '0;
                rd_q[s]  <= '0;
                cnt_q[s] <= '0;
            end
            seq_q   <= '0;
            wcon_q  <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_q[s]  <= wr_d[s];
                rd_q[s]  <= rd_d[s];
                cnt_q[s] <= cnt_d[s];
            end
            seq_q   <= seq_d;
            wcon_q  <= wcon_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    // Queue storage; contents are qualified by the counts, so no reset needed
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_reg_q[s][i] <= q_reg_d[s][i];
            end
            if (enq[s]) begin
                q_data_q[s][wr_q[s]] <= in_data[s];
                q_seq_q[s][wr_q[s]]  <= enq_seq[s];
            end
        end
    end

    assign alu_ready_o    = in_ready[ALU];
    assign mem_ready_o    = in_ready[MEM];
    assign alu_count_o    = cnt_q[ALU];
    assign mem_count_o    = cnt_q[MEM];
    assign regwrite_con_o = wcon_q;
    assign reg_write_o    = wreg_q;
    assign write_data_o   = wdata_q;
    assign pend_mask_o    = pend_q;

endmodule
